// File: rtl/llsc_reservation_ctrl.sv
// llsc_reservation_ctrl: LL/SC reservation tracker for the CPU core.
// LL arms a link bit on an address granule. Core stores, external snoops,
// flushes and an idle timeout disarm it. A successful SC is sequenced
// through a store handshake with the memory stage before it resolves.
module llsc_reservation_ctrl #(
    parameter int AW       = 32,
    parameter int GRAN_LSB = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ll_valid,
    input  logic [AW-1:0] ll_addr,
    input  logic          sc_valid,
    input  logic [AW-1:0] sc_addr,
    output logic          sc_ready,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic          snoop_valid,
    input  logic [AW-1:0] snoop_addr,
    output logic          mem_st_req,
    input  logic          mem_st_ack,
    output logic          sc_done,
    output logic          sc_result,
    output logic          llbit_o,
    output logic [AW-1:0] rsv_addr_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RSV     = 2'd1,
        SC_WAIT = 2'd2
    } state_t;

    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int            TLAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TLAST   = TLAST_I[CW-1:0];
    localparam logic [CW-1:0] TSAT    = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] rsv_addr_q, rsv_addr_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          sc_done_q, sc_done_d;
    logic          sc_result_q, sc_result_d;

    logic          sc_match;
    logic          st_hit;
    logic          snoop_hit;
    logic          timer_expired;

    // The link bit is exactly "not IDLE": it stays set while the SC store is
    // in flight and drops on the edge that resolves it.
    assign llbit_o    = (state_q != IDLE);
    assign sc_ready   = (state_q != SC_WAIT);
    assign mem_st_req = (state_q == SC_WAIT);
    assign sc_done    = sc_done_q;
    assign sc_result  = sc_result_q;
    assign rsv_addr_o = rsv_addr_q;

    // Granule compares against the live reservation.
    assign sc_match  = llbit_o && (sc_addr[AW-1:GRAN_LSB] == rsv_addr_q[AW-1:GRAN_LSB]);
    assign st_hit    = st_valid && llbit_o &&
                       (st_addr[AW-1:GRAN_LSB] == rsv_addr_q[AW-1:GRAN_LSB]);
    assign snoop_hit = snoop_valid && llbit_o &&
                       (snoop_addr[AW-1:GRAN_LSB] == rsv_addr_q[AW-1:GRAN_LSB]);
    assign timer_expired = (TIMEOUT != 0) && (state_q == RSV) && (timer_q == TLAST);

    // State and datapath registers, cleared asynchronously.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rsv_addr_q  <= '0;
            timer_q     <= '0;
            sc_done_q   <= 1'b0;
            sc_result_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsv_addr_q  <= rsv_addr_d;
            timer_q     <= timer_d;
            sc_done_q   <= sc_done_d;
            sc_result_q <= sc_result_d;
        end
    end

    // Next-state logic: flush > SC > LL > store/snoop kill > timeout.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RSV: begin
                if (flush)                   state_d = IDLE;
                else if (sc_valid)           state_d = sc_match ? SC_WAIT : IDLE;
                else if (ll_valid)           state_d = RSV;
                else if (st_hit || snoop_hit) state_d = IDLE;
                else if (timer_expired)      state_d = IDLE;
            end
            SC_WAIT: begin
                // The ack wins over a same-cycle flush: the store has landed.
                if (mem_st_ack || flush)     state_d = IDLE;
            end
            default:                         state_d = IDLE;
        endcase
    end

    // Datapath next values: captured address, idle timer and SC resolution.
    always_comb begin
        rsv_addr_d  = rsv_addr_q;
        timer_d     = '0;
        sc_done_d   = 1'b0;
        sc_result_d = 1'b0;
        unique case (state_q)
            IDLE, RSV: begin
                if (flush) begin
                    // Same-cycle LL or SC is dropped without a response.
                end else if (sc_valid) begin
                    if (!sc_match) sc_done_d = 1'b1;
                end else if (ll_valid) begin
                    rsv_addr_d = ll_addr;
                end else if (st_hit || snoop_hit || timer_expired) begin
                    // Reservation lost; timer restarts from zero.
                end else if (state_q == RSV && TIMEOUT != 0) begin
                    timer_d = (timer_q == TSAT) ? timer_q : timer_q + 1'b1;
                end
            end
            SC_WAIT: begin
                if (mem_st_ack) begin
                    sc_done_d   = 1'b1;
                    sc_result_d = 1'b1;
                end else if (flush) begin
                    sc_done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
